// File: rtl/fpu_pkg.sv
// Shared FPU coprocessor package.
//   fpuMulSeqState_t : sequencer states of the multi-cycle multiplier
//   condCode_t       : {Z, C, N, V} condition code bundle
//   fpQNaN/fpInf/fpZero : special-value encodings for any EXPW/FRACW,
//                         returned right-aligned in 64 bits (caller truncates)
package fpu_pkg;

  typedef enum logic [1:0] {IDLE, MUL, ROUND, DONE} fpuMulSeqState_t;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } condCode_t;

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [63:0] fpQNaN(input int expw, input int fracw);
    logic [63:0] r;
    r = ((64'd1 << expw) - 64'd1) << fracw;
    r = r | (64'd1 << (fracw - 1));
    return r;
  endfunction

  function automatic logic [63:0] fpInf(input logic sign, input int expw, input int fracw);
    return (((64'd1 << expw) - 64'd1) << fracw) | (64'(sign) << (expw + fracw));
  endfunction

  function automatic logic [63:0] fpZero(input logic sign, input int expw, input int fracw);
    return 64'(sign) << (expw + fracw);
  endfunction

endpackage

// File: rtl/fpu_seq_multiplier.sv
// Unsigned shift-add multiplier, one partial product per cycle.
//   clock, reset : clock, async active-high reset
//   start        : load a/b; the bit-0 partial product is taken on this edge
//   a, b         : W-bit unsigned operands
//   product      : 2W-bit product, stable once done is high
//   done         : all W partial products accumulated (also high when idle)
module fpu_seq_multiplier
  import fpu_pkg::*;
#(
  parameter int W = 11
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product,
  output logic           done
);
  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
    end else if (start) begin
      // Fold the first partial product into the load so the whole
      // product is ready W-1 edges after start.
      mcand   <= {{(W-1){1'b0}}, a, 1'b0};
      mplier  <= b >> 1;
      product <= b[0] ? {{W{1'b0}}, a} : '0;
      cnt     <= CW'(W - 1);
    end else if (cnt != '0) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/fpu_mul_seq.sv
// Sequential IEEE-754-style multiplier, parametrised by EXPW/FRACW.
// Round-to-nearest-even, subnormal in/out, inf/NaN/zero handling.
//   clock, reset     : clock, async active-high reset
//   start            : begin op (honoured only in IDLE or DONE)
//   fpuIn1, fpuIn2   : operands {sign, exp, frac}, latched on accepted start
//   fpuOut           : product, updated on the ROUND->DONE edge only
//   done             : high while in DONE
//   busy             : high in MUL or ROUND
//   condCodes        : {Z, C, N, V}, updated with fpuOut
module fpu_mul_seq
  import fpu_pkg::*;
#(
  parameter int EXPW  = 5,
  parameter int FRACW = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [EXPW+FRACW:0]   fpuIn1,
  input  logic [EXPW+FRACW:0]   fpuIn2,
  output logic [EXPW+FRACW:0]   fpuOut,
  output logic                  done,
  output logic                  busy,
  output logic [3:0]            condCodes
);
  localparam int TW   = 1 + EXPW + FRACW;
  localparam int W    = FRACW + 1;
  localparam int PW   = 2 * W;
  localparam int EW   = EXPW + 2;
  localparam int LW   = $clog2(PW);
  localparam int BIAS = 2**(EXPW-1) - 1;
  localparam logic [EXPW-1:0] EXPMAX = '1;
  localparam logic [TW-1:0]   QNAN   = TW'(fpQNaN(EXPW, FRACW));

  fpuMulSeqState_t state, stateNext;
  logic [TW-1:0]   opA, opB;
  logic            accept, mulDone;
  logic [PW-1:0]   prod;
  condCode_t       ccReg, ccNext;
  logic [TW-1:0]   resNext;

  assign accept = start && (state == IDLE || state == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = MUL;
      MUL:     if (mulDone) stateNext = ROUND;
      ROUND:   stateNext = DONE;
      DONE:    if (start) stateNext = MUL;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opA    <= '0;
      opB    <= '0;
      fpuOut <= '0;
      ccReg  <= '0;
    end else begin
      if (accept) begin
        opA <= fpuIn1;
        opB <= fpuIn2;
      end
      if (state == ROUND) begin
        fpuOut <= resNext;
        ccReg  <= ccNext;
      end
    end
  end

  assign done      = (state == DONE);
  assign busy      = (state == MUL) || (state == ROUND);
  assign condCodes = ccReg;

  // Significands come straight from the inputs because the multiplier
  // loads on the same edge that latches opA/opB.
  fpu_seq_multiplier #(.W(W)) uMul (
    .clock   (clock),
    .reset   (reset),
    .start   (accept),
    .a       ({|fpuIn1[TW-2 -: EXPW], fpuIn1[FRACW-1:0]}),
    .b       ({|fpuIn2[TW-2 -: EXPW], fpuIn2[FRACW-1:0]}),
    .product (prod),
    .done    (mulDone)
  );

  // Operand classification from the latched copies.
  logic             sgn;
  logic [EXPW-1:0]  eA, eB, effA, effB;
  logic [FRACW-1:0] fA, fB;
  logic             nanA, nanB, infA, infB, zeroA, zeroB;

  assign sgn   = opA[TW-1] ^ opB[TW-1];
  assign eA    = opA[TW-2 -: EXPW];
  assign eB    = opB[TW-2 -: EXPW];
  assign fA    = opA[FRACW-1:0];
  assign fB    = opB[FRACW-1:0];
  assign effA  = (eA == '0) ? EXPW'(1) : eA;
  assign effB  = (eB == '0) ? EXPW'(1) : eB;
  assign nanA  = (eA == EXPMAX) && (fA != '0);
  assign nanB  = (eB == EXPMAX) && (fB != '0);
  assign infA  = (eA == EXPMAX) && (fA == '0);
  assign infB  = (eB == EXPMAX) && (fB == '0);
  assign zeroA = (eA == '0) && (fA == '0);
  assign zeroB = (eB == '0) && (fB == '0);

  logic [LW-1:0]          msb;
  logic [PW-1:0]          norm, denorm;
  logic signed [EW-1:0]   expN;
  logic [EW-1:0]          shAmt, expField;
  logic [EW+FRACW-1:0]    packedRes;
  logic                   denormRes, shSticky, guard, sticky, roundUp, ovf;

  always_comb begin
    msb = '0;
    for (int i = 0; i < PW; i++)
      if (prod[i]) msb = LW'(i);

    // Leading one to the top bit; bit PW-1 is then the hidden bit.
    norm = prod << (LW'(PW - 1) - msb);
    // Biased exponent of the normalised value: 1.0 sits at bit 2*FRACW.
    expN = EW'(effA) + EW'(effB) + EW'(msb) - EW'(BIAS + 2*FRACW);

    denormRes = expN[EW-1] || (expN == '0);
    shAmt     = denormRes ? (EW'(1) - expN) : '0;
    denorm    = norm >> shAmt;
    shSticky  = ((denorm << shAmt) != norm);

    guard   = denorm[PW-1-W];
    sticky  = (|denorm[PW-2-W:0]) | shSticky;
    roundUp = guard & (sticky | denorm[PW-W]);

    // Rounding on the packed {exp, frac} lets a fraction carry bump the
    // exponent and a subnormal carry land on the minimum normal for free.
    expField  = denormRes ? '0 : expN;
    packedRes = {expField, denorm[PW-2 -: FRACW]} + (EW+FRACW)'(roundUp);
    ovf       = packedRes[EW+FRACW-1 -: EW] >= EW'(2**EXPW - 1);

    resNext = {sgn, packedRes[EXPW+FRACW-1:0]};
    ccNext  = '{z: (packedRes == '0), c: guard | sticky, n: sgn, v: 1'b0};

    if (ovf) begin
      resNext = TW'(fpInf(sgn, EXPW, FRACW));
      ccNext  = '{z: 1'b0, c: 1'b1, n: sgn, v: 1'b1};
    end

    if (nanA || nanB || (infA && zeroB) || (zeroA && infB)) begin
      resNext = QNAN;
      ccNext  = '0;
    end else if (infA || infB) begin
      resNext = TW'(fpInf(sgn, EXPW, FRACW));
      ccNext  = '{z: 1'b0, c: 1'b0, n: sgn, v: 1'b0};
    end else if (zeroA || zeroB) begin
      resNext = TW'(fpZero(sgn, EXPW, FRACW));
      ccNext  = '{z: 1'b1, c: 1'b0, n: sgn, v: 1'b0};
    end
  end

endmodule

// File: tb/tb_fpu_mul_seq.sv
// Bench for fpu_mul_seq at FP16 defaults: directed vector table, multi-cycle
// corner sequences (back-to-back, mid-op reset) and random operands checked
// against an exact quantum-rounding reference model.
module tb_fpu_mul_seq;

  logic        clock, reset, start, done, busy;
  logic [15:0] fpuIn1, fpuIn2, fpuOut;
  logic [3:0]  condCodes;

  int total = 0;
  int bad   = 0;
  logic [15:0] lastOut;

  fpu_mul_seq #(.EXPW(5), .FRACW(10)) dut (
    .clock(clock), .reset(reset), .start(start),
    .fpuIn1(fpuIn1), .fpuIn2(fpuIn2),
    .fpuOut(fpuOut), .done(done), .busy(busy), .condCodes(condCodes)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Exact model: value = ma*mb * 2^sc; pick the result exponent, express the
  // value in units of its quantum, then round-half-even on the remainder.
  function automatic logic [19:0] refMul(input logic [15:0] a, input logic [15:0] b);
    logic s, nanA, nanB, infA, infB, zeroA, zeroB, inexact;
    int ea, eb, fa, fb, ma, mb, xa, xb, sc, msb, k, eu, d, ef;
    longint p, n, r, half;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    nanA = (ea == 31 && fa != 0); nanB = (eb == 31 && fb != 0);
    infA = (ea == 31 && fa == 0); infB = (eb == 31 && fb == 0);
    zeroA = (ea == 0 && fa == 0); zeroB = (eb == 0 && fb == 0);
    if (nanA || nanB || (infA && zeroB) || (zeroA && infB)) return {4'b0000, 16'h7E00};
    if (infA || infB) return {2'b00, s, 1'b0, s, 15'h7C00};
    if (zeroA || zeroB) return {1'b1, 1'b0, s, 1'b0, s, 15'h0000};
    ma = (ea == 0) ? fa : fa + 1024;  xa = (ea == 0) ? 1 : ea;
    mb = (eb == 0) ? fb : fb + 1024;  xb = (eb == 0) ? 1 : eb;
    p  = longint'(ma) * longint'(mb);
    sc = (xa - 15) + (xb - 15) - 20;
    msb = 0;
    for (int i = 0; i < 40; i++) if (p[i]) msb = i;
    k  = msb + sc;
    eu = (k < -14) ? -14 : k;
    d  = eu - 10 - sc;
    inexact = 1'b0;
    if (d <= 0) n = p << (-d);
    else if (d > 60) begin n = 0; inexact = 1'b1; end
    else begin
      n = p >> d;
      r = p - (n << d);
      half = longint'(1) << (d - 1);
      if (r > half || (r == half && n[0])) n++;
      inexact = (r != 0);
    end
    if (n >= 2048) begin n = n >> 1; eu++; end
    ef = (n >= 1024) ? eu + 15 : 0;
    if (ef >= 31) return {2'b01, s, 1'b1, s, 15'h7C00};
    return {(n == 0), inexact, s, 1'b0, s, 5'(ef), n[9:0]};
  endfunction

  function automatic logic [15:0] randOp();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 7))
      0: v[14:10] = 5'd0;
      1: v[14:10] = 5'h1f;
      2: v[14:0]  = 15'd0;
      3: v[14:10] = 5'($urandom_range(1, 8));
      4: v[14:10] = 5'($urandom_range(22, 30));
      default: ;
    endcase
    return v;
  endfunction

  // Launch one op from IDLE/DONE. start is held for holdStart edges (the
  // extra edges fall in MUL and must be ignored); operands are scrambled
  // after the sampling edge. Checks latency, busy, and that the previous
  // result holds until the new one lands.
  task automatic runOp(input logic [15:0] a, input logic [15:0] b, input int holdStart,
                       input string tag, output logic [15:0] res, output logic [3:0] cc);
    int lat, busyBad, heldBad;
    @(negedge clock);
    fpuIn1 = a; fpuIn2 = b; start = 1'b1;
    @(posedge clock); #1;
    lat = 1; busyBad = 0; heldBad = 0;
    while (!done && lat < 40) begin
      if (lat >= holdStart) start = 1'b0;
      fpuIn1 = 16'($urandom); fpuIn2 = 16'($urandom);
      if (!busy) busyBad++;
      if (fpuOut !== lastOut) heldBad++;
      @(posedge clock); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'd13);
    check({tag, " busyLowAtDone"}, 32'(busy), 32'd0);
    check({tag, " busyDuringOp"}, 32'(busyBad), 32'd0);
    check({tag, " priorHeld"}, 32'(heldBad), 32'd0);
    res = fpuOut; cc = condCodes;
    lastOut = fpuOut;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic [3:0]  cc;
    string       name;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] res;
    logic [3:0]  cc;
    logic [19:0] exp;
    logic [15:0] a, b;

    tbl[0] = '{16'h3E00, 16'h4000, 16'h4200, 4'b0000, "1.5x2"};
    tbl[1] = '{16'h3C01, 16'h3C01, 16'h3C02, 4'b0100, "inexact"};
    tbl[2] = '{16'h7BFF, 16'h4000, 16'h7C00, 4'b0101, "overflow"};
    tbl[3] = '{16'h0001, 16'h3800, 16'h0000, 4'b1100, "subTieZero"};
    tbl[4] = '{16'h0200, 16'h4000, 16'h0400, 4'b0000, "subToMinNorm"};
    tbl[5] = '{16'h7C00, 16'h0000, 16'h7E00, 4'b0000, "infTimesZero"};
    tbl[6] = '{16'hFC00, 16'h4000, 16'hFC00, 4'b0010, "negInf"};
    tbl[7] = '{16'hC000, 16'h3C00, 16'hC000, 4'b0010, "negExact"};
    tbl[8] = '{16'h7E01, 16'h3C00, 16'h7E00, 4'b0000, "nanIn"};
    tbl[9] = '{16'h8000, 16'h4000, 16'h8000, 4'b1010, "negZero"};

    reset = 1'b1; start = 1'b0; fpuIn1 = '0; fpuIn2 = '0;
    #1;
    check("reset fpuOut", 32'(fpuOut), 32'd0);
    check("reset condCodes", 32'(condCodes), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    lastOut = 16'h0000;
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      runOp(tbl[i].a, tbl[i].b, 1, tbl[i].name, res, cc);
      check({tbl[i].name, " fpuOut"}, 32'(res), 32'(tbl[i].out));
      check({tbl[i].name, " condCodes"}, 32'(cc), 32'(tbl[i].cc));
    end

    // Back-to-back from DONE with start held into MUL.
    runOp(16'h3E00, 16'h4000, 1, "b2bFirst", res, cc);
    check("b2bFirst fpuOut", 32'(res), 32'h4200);
    runOp(16'h3C01, 16'h3C01, 5, "b2bSecond", res, cc);
    check("b2bSecond fpuOut", 32'(res), 32'h3C02);
    check("b2bSecond condCodes", 32'(cc), 32'b0100);

    // Reset in the middle of MUL.
    @(negedge clock);
    fpuIn1 = 16'h7BFF; fpuIn2 = 16'h4000; start = 1'b1;
    repeat (5) @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock) reset = 1'b1;
    #1;
    check("midReset fpuOut", 32'(fpuOut), 32'd0);
    check("midReset condCodes", 32'(condCodes), 32'd0);
    check("midReset done", 32'(done), 32'd0);
    check("midReset busy", 32'(busy), 32'd0);
    lastOut = 16'h0000;
    @(negedge clock) reset = 1'b0;
    runOp(16'h3E00, 16'h4000, 1, "afterReset", res, cc);
    check("afterReset fpuOut", 32'(res), 32'h4200);
    check("afterReset condCodes", 32'(cc), 32'd0);

    for (int i = 0; i < 150; i++) begin
      a = randOp(); b = randOp();
      exp = refMul(a, b);
      runOp(a, b, 1 + int'($urandom_range(0, 2)), "rand", res, cc);
      if (res !== exp[15:0] || cc !== exp[19:16])
        $display("  operands %h x %h", a, b);
      check("rand fpuOut", 32'(res), 32'(exp[15:0]));
      check("rand condCodes", 32'(cc), 32'(exp[19:16]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
